therm2bin_pipeline_bubble: RTL and testbench

Parametrised successor to the team's pipelined flash-ADC thermometer-to-binary encoder. It takes the raw 2**B-1 comparator outputs of one flash conversion per valid cycle and applies 3-tap majority bubble correction. It then resolves one binary bit per pipeline stage by binary search. Each output sample carries a valid strobe plus bubble, overflow and underflow flags. A saturating bubble counter is provided for ADC health monitoring.

---
 rtl/therm2bin_pipeline_bubble.sv | 172 +++++++++++++++++
 tb/tb_therm2bin_pipeline_bubble.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/therm2bin_pipeline_bubble.sv
// Pipelined flash-ADC thermometer-to-binary encoder with 3-tap majority
// bubble correction, one binary-search stage per output bit, per-sample
// bubble/overflow/underflow flags and a saturating bubble counter.
module therm2bin_pipeline_bubble #(
   parameter int unsigned B          = 6,
   parameter int unsigned BUBBLE_FIX = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [(1<<B)-2:0]     thermo,
   input  logic                  clr_cnt,
   output logic                  valid_out,
   output logic [B-1:0]          bin,
   output logic                  bubble,
   output logic                  ovr,
   output logic                  und,
   output logic [CNT_W-1:0]      bubble_cnt
);

   localparam int unsigned N = (1 << B) - 1;
   localparam logic [N-1:0] ALL_ONES = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Index of the bit tested by search stage k inside its window.
   function automatic int unsigned test_idx(input int unsigned k);
      return (32'd1 << (B - k)) - 32'd1;
   endfunction

   // Stage 0: raw capture of the comparator word.
   logic          s0_vld;
   logic [N-1:0]  s0_therm;

   // Majority correction and per-sample flags derived from stage 0.
   logic [N-1:0]  t_lo;
   logic [N-1:0]  t_hi;
   logic [N-1:0]  corr;
   logic [N-1:0]  srch;
   logic          s0_bub;
   logic          s0_ovr;
   logic          s0_und;

   // Search stage registers (stage k holds the window after resolving bit B-k).
   logic [N-1:0]  st_win  [1:B];
   logic [B-1:0]  st_bits [1:B];
   logic          st_vld  [1:B];
   logic          st_bub  [1:B];
   logic          st_ovr  [1:B];
   logic          st_und  [1:B];

   logic [N-1:0]  w_src    [1:B];
   logic          hit      [1:B];
   logic [N-1:0]  nxt_win  [1:B];
   logic [B-1:0]  nxt_bits [1:B];
   logic          nxt_vld  [1:B];
   logic          nxt_bub  [1:B];
   logic          nxt_ovr  [1:B];
   logic          nxt_und  [1:B];

   // Stage 0 register: free-running capture, valid is a plain shift chain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s0_vld   <= 1'b0;
         s0_therm <= '0;
      end else begin
         s0_vld   <= valid_in;
         s0_therm <= thermo;
      end
   end

   // Neighbour taps with t[-1]=1 below and t[N]=0 above.
   assign t_lo   = {s0_therm[N-2:0], 1'b1};
   assign t_hi   = {1'b0, s0_therm[N-1:1]};
   assign corr   = (t_lo & s0_therm) | (t_lo & t_hi) | (s0_therm & t_hi);
   assign srch   = (BUBBLE_FIX != 0) ? corr : s0_therm;
   assign s0_bub = (corr != s0_therm);
   assign s0_und = (s0_therm == '0);
   assign s0_ovr = (s0_therm == ALL_ONES);

   // Binary-search step per stage: test the window midpoint, keep the half it selects.
   always_comb begin
      for (int k = 1; k <= B; k++) begin
         w_src[k]    = '0;
         hit[k]      = 1'b0;
         nxt_win[k]  = '0;
         nxt_bits[k] = '0;
         nxt_vld[k]  = 1'b0;
         nxt_bub[k]  = 1'b0;
         nxt_ovr[k]  = 1'b0;
         nxt_und[k]  = 1'b0;
      end
      for (int k = 1; k <= B; k++) begin
         if (k == 1) begin
            w_src[k]    = srch;
            nxt_bits[k] = '0;
            nxt_vld[k]  = s0_vld;
            nxt_bub[k]  = s0_bub;
            nxt_ovr[k]  = s0_ovr;
            nxt_und[k]  = s0_und;
         end else begin
            w_src[k]    = st_win[k-1];
            nxt_bits[k] = st_bits[k-1];
            nxt_vld[k]  = st_vld[k-1];
            nxt_bub[k]  = st_bub[k-1];
            nxt_ovr[k]  = st_ovr[k-1];
            nxt_und[k]  = st_und[k-1];
         end
         hit[k] = |((w_src[k] >> test_idx(k)) & N'(1));
         if (hit[k]) begin
            nxt_win[k] = (w_src[k] >> (test_idx(k) + 1)) & ~(ALL_ONES << test_idx(k));
         end else begin
            nxt_win[k] = w_src[k] & ~(ALL_ONES << test_idx(k));
         end
         nxt_bits[k] = nxt_bits[k] | (B'(hit[k]) << (B - k));
      end
   end

   // Search stage registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= B; k++) begin
            st_win[k]  <= '0;
            st_bits[k] <= '0;
            st_vld[k]  <= 1'b0;
            st_bub[k]  <= 1'b0;
            st_ovr[k]  <= 1'b0;
            st_und[k]  <= 1'b0;
         end
      end else begin
         for (int k = 1; k <= B; k++) begin
            st_win[k]  <= nxt_win[k];
            st_bits[k] <= nxt_bits[k];
            st_vld[k]  <= nxt_vld[k];
            st_bub[k]  <= nxt_bub[k];
            st_ovr[k]  <= nxt_ovr[k];
            st_und[k]  <= nxt_und[k];
         end
      end
   end

   // Output register: bin holds between samples, flags only assert with valid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_out <= 1'b0;
         bin       <= '0;
         bubble    <= 1'b0;
         ovr       <= 1'b0;
         und       <= 1'b0;
      end else begin
         valid_out <= st_vld[B];
         bubble    <= st_vld[B] & st_bub[B];
         ovr       <= st_vld[B] & st_ovr[B];
         und       <= st_vld[B] & st_und[B];
         if (st_vld[B]) begin
            bin <= st_bits[B];
         end
      end
   end

   // Saturating bubble counter; clear wins over a same-cycle increment.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bubble_cnt <= '0;
      end else if (clr_cnt) begin
         bubble_cnt <= '0;
      end else if (valid_out && bubble && (bubble_cnt != CNT_MAX)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_therm2bin_pipeline_bubble.sv
// Bench for therm2bin_pipeline_bubble: three instances (B=4 corrected,
// B=4 bypass, B=6 defaults) checked every cycle against a reference model.
module tb_therm2bin_pipeline_bubble;

   logic        clock;
   logic        reset;
   logic        v_ab, v_c, clr;
   logic [14:0] t_ab;
   logic [62:0] t_c;

   logic        vo_a, bub_a, ovr_a, und_a;
   logic [3:0]  bin_a, cnt_a;
   logic        vo_b, bub_b, ovr_b, und_b;
   logic [3:0]  bin_b, cnt_b;
   logic        vo_c, bub_c, ovr_c, und_c;
   logic [5:0]  bin_c;
   logic [15:0] cnt_c;

   therm2bin_pipeline_bubble #(.B(4), .BUBBLE_FIX(1), .CNT_W(4)) dut_a (
      .clock(clock), .reset(reset), .valid_in(v_ab), .thermo(t_ab), .clr_cnt(clr),
      .valid_out(vo_a), .bin(bin_a), .bubble(bub_a), .ovr(ovr_a), .und(und_a),
      .bubble_cnt(cnt_a));

   therm2bin_pipeline_bubble #(.B(4), .BUBBLE_FIX(0), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .valid_in(v_ab), .thermo(t_ab), .clr_cnt(clr),
      .valid_out(vo_b), .bin(bin_b), .bubble(bub_b), .ovr(ovr_b), .und(und_b),
      .bubble_cnt(cnt_b));

   therm2bin_pipeline_bubble dut_c (
      .clock(clock), .reset(reset), .valid_in(v_c), .thermo(t_c), .clr_cnt(clr),
      .valid_out(vo_c), .bin(bin_c), .bubble(bub_c), .ovr(ovr_c), .und(und_c),
      .bubble_cnt(cnt_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int bw   [3] = '{4, 4, 6};
   int fixw [3] = '{1, 0, 1};
   int cmax [3] = '{15, 15, 65535};

   // Per-edge input history, used to predict outputs B+1 edges later.
   bit          h_v   [0:2][0:4095];
   logic [62:0] h_t   [0:2][0:4095];
   bit          rst_h [0:4095];
   bit          clr_h [0:4095];

   int last_bin [3];
   int cnt_m    [3];
   bit pend     [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: per-bit majority vote, then bisection over code index.
   function automatic void ref_model(input logic [62:0] t, input int b, input int fix,
                                     output int code, output bit bub, output bit ov,
                                     output bit un);
      int n, base, half, votes;
      bit c [0:62];
      bit l, h, sel;
      n = (1 << b) - 1;
      bub = 0; ov = 1; un = 1;
      for (int i = 0; i < n; i++) begin
         l = (i == 0) ? 1'b1 : t[i-1];
         h = (i == n - 1) ? 1'b0 : t[i+1];
         votes = int'(l) + int'(t[i]) + int'(h);
         c[i] = (votes >= 2);
         if (c[i] != t[i]) bub = 1;
         if (t[i]) un = 0; else ov = 0;
      end
      code = 0; base = 0;
      for (int k = 1; k <= b; k++) begin
         half = 1 << (b - k);
         sel  = (fix != 0) ? c[base + half - 1] : t[base + half - 1];
         if (sel) begin
            code += half;
            base += half;
         end
      end
   endfunction

   task automatic check_dut(input int d, input int n);
      logic o_v, o_bub, o_ovr, o_und;
      logic [63:0] o_bin, o_cnt;
      bit e_v, e_bub, e_ovr, e_und;
      int e_bin, idx;
      case (d)
         0: begin o_v = vo_a; o_bin = 64'(bin_a); o_bub = bub_a; o_ovr = ovr_a; o_und = und_a; o_cnt = 64'(cnt_a); end
         1: begin o_v = vo_b; o_bin = 64'(bin_b); o_bub = bub_b; o_ovr = ovr_b; o_und = und_b; o_cnt = 64'(cnt_b); end
         default: begin o_v = vo_c; o_bin = 64'(bin_c); o_bub = bub_c; o_ovr = ovr_c; o_und = und_c; o_cnt = 64'(cnt_c); end
      endcase
      e_v = 0; e_bub = 0; e_ovr = 0; e_und = 0;
      if (!rst_h[n]) begin
         cnt_m[d] = 0; pend[d] = 0; last_bin[d] = 0;
      end else begin
         if (clr_h[n]) cnt_m[d] = 0;
         else if (pend[d] && cnt_m[d] < cmax[d]) cnt_m[d]++;
         idx = n - (bw[d] + 1);
         if (idx >= 1 && h_v[d][idx]) begin
            ref_model(h_t[d][idx], bw[d], fixw[d], e_bin, e_bub, e_ovr, e_und);
            e_v = 1;
            last_bin[d] = e_bin;
            if (d == 2) chk($sformatf("dut2.popcount@%0d", n), o_bin, 64'($countones(h_t[d][idx])));
         end
         pend[d] = e_v && e_bub;
      end
      chk($sformatf("dut%0d.valid_out@%0d", d, n), 64'(o_v), 64'(e_v));
      chk($sformatf("dut%0d.bin@%0d", d, n), o_bin, 64'(last_bin[d]));
      chk($sformatf("dut%0d.bubble@%0d", d, n), 64'(o_bub), 64'(e_bub));
      chk($sformatf("dut%0d.ovr@%0d", d, n), 64'(o_ovr), 64'(e_ovr));
      chk($sformatf("dut%0d.und@%0d", d, n), 64'(o_und), 64'(e_und));
      chk($sformatf("dut%0d.bubble_cnt@%0d", d, n), o_cnt, 64'(cnt_m[d]));
   endtask

   // One clock: record what the edge captures, then check on the falling edge.
   task automatic tick();
      @(posedge clock);
      cyc++;
      rst_h[cyc] = reset;
      clr_h[cyc] = clr;
      h_v[0][cyc] = v_ab & reset; h_t[0][cyc] = 63'(t_ab);
      h_v[1][cyc] = v_ab & reset; h_t[1][cyc] = 63'(t_ab);
      h_v[2][cyc] = v_c & reset;  h_t[2][cyc] = t_c;
      @(negedge clock);
      for (int d = 0; d < 3; d++) check_dut(d, cyc);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".a"}, {55'd0, vo_a, bin_a, bub_a, ovr_a, und_a, cnt_a}, 64'd0);
      chk({tag, ".b"}, {55'd0, vo_b, bin_b, bub_b, ovr_b, und_b, cnt_b}, 64'd0);
      chk({tag, ".c"}, {39'd0, vo_c, bin_c, bub_c, ovr_c, und_c, cnt_c}, 64'd0);
   endtask

   logic [14:0] mono15;
   int k_rand, sent, sel;

   initial begin
      reset = 1'b0; v_ab = 0; v_c = 0; clr = 0; t_ab = '0; t_c = '0;
      repeat (3) tick();
      check_zero("reset_state");
      reset = 1'b1;

      // Mid-scale monotonic code.
      v_ab = 1; t_ab = 15'h007F; tick();
      v_ab = 0; t_ab = '0; repeat (6) tick();

      // Single bubble at bit 4, seen by corrected and bypass instances.
      v_ab = 1; t_ab = 15'h01EF; tick();
      v_ab = 0; t_ab = '0; repeat (6) tick();

      // Full scale then zero scale back to back.
      v_ab = 1; t_ab = 15'h7FFF; tick();
      t_ab = 15'h0000; tick();
      v_ab = 0; repeat (6) tick();

      // Random traffic with gaps; B=6 gets 100 monotonic samples.
      sent = 0;
      while (sent < 100) begin
         v_c = ($urandom_range(0, 3) != 0);
         k_rand = $urandom_range(0, 63);
         t_c = (k_rand == 63) ? {63{1'b1}} : ((63'(1) << k_rand) - 63'(1));
         if (v_c) sent++;
         v_ab = ($urandom_range(0, 1) == 1);
         k_rand = $urandom_range(0, 15);
         mono15 = (k_rand == 15) ? 15'h7FFF : ((15'(1) << k_rand) - 15'(1));
         sel = $urandom_range(0, 3);
         if (sel == 0) t_ab = mono15 ^ (15'(1) << $urandom_range(0, 14));
         else if (sel == 1) t_ab = 15'($urandom());
         else t_ab = mono15;
         tick();
      end
      v_c = 0; v_ab = 0; repeat (8) tick();

      // Counter saturation, then a clear coinciding with a bubbly output.
      v_ab = 1; t_ab = 15'h01EF;
      for (int i = 0; i < 30; i++) begin
         clr = (i == 25);
         tick();
      end
      clr = 0; v_ab = 0; repeat (8) tick();

      // Reset pulse with three samples in flight.
      v_ab = 1; v_c = 1;
      t_ab = 15'h003F; t_c = 63'h0000_0000_FFFF_FFFF; tick();
      t_ab = 15'h7FFF; t_c = 63'h0000_0000_0000_0001; tick();
      t_ab = 15'h0FEF; t_c = {63{1'b1}}; tick();
      v_ab = 0; v_c = 0;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      for (int d = 0; d < 3; d++)
         for (int i = 0; i <= cyc; i++) h_v[d][i] = 0;
      tick();
      reset = 1'b1;
      tick();
      v_ab = 1; v_c = 1; t_ab = 15'h001F; t_c = 63'h0000_0000_0000_07FF; tick();
      v_ab = 0; v_c = 0; repeat (9) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
